// File: rtl/reg_bank_pkg.sv
// Shared sizing defaults and dump-engine state encoding for the register bank.
package reg_bank_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned ADDR_W    = $clog2(DEF_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_bank_dump_fsm.sv
// Dump sequencer: walks the register index 0..DEPTH-1 once per accepted start.
module reg_bank_dump_fsm
  import reg_bank_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [$clog2(DEPTH)-1:0]   idx,
  output logic                       valid,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  dump_state_e   state, state_n;
  logic [AW-1:0] idx_n;
  logic          active, active_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      active <= active_n;
    end
  end

  // Start is honoured only from IDLE; the last index hands over to DONE.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    active_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n  = DUMP;
          idx_n    = '0;
          active_n = 1'b1;
        end
      end
      DUMP: begin
        idx_n = idx + AW'(1);
        if (idx == AW'(DEPTH - 1)) begin
          state_n = DONE;
        end else begin
          active_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign valid = active;
  assign busy  = active;

endmodule

// File: rtl/reg_bank.sv
// General register file with two registered read ports, write bypass and a debug dump port.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     WE,
  input  logic [$clog2(DEPTH)-1:0] DIR_W,
  input  logic [WIDTH-1:0]         Dato_Registro,
  input  logic                     RD_REQ,
  input  logic [$clog2(DEPTH)-1:0] DIR_X,
  input  logic [$clog2(DEPTH)-1:0] DIR_Y,
  output logic [WIDTH-1:0]         RX,
  output logic [WIDTH-1:0]         RY,
  output logic                     RD_VALID,
  input  logic                     DUMP_START,
  output logic [WIDTH-1:0]         DUMP_DATA,
  output logic [$clog2(DEPTH)-1:0] DUMP_IDX,
  output logic                     DUMP_VALID,
  output logic                     BUSY
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rx_c, ry_c;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (WE) begin
      mem[DIR_W] <= Dato_Registro;
    end
  end

  // Same-cycle write wins over stored contents on every read path.
  always_comb begin
    rx_c = mem[DIR_X];
    ry_c = mem[DIR_Y];
    if (WE && (DIR_W == DIR_X)) rx_c = Dato_Registro;
    if (WE && (DIR_W == DIR_Y)) ry_c = Dato_Registro;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RX       <= '0;
      RY       <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= RD_REQ;
      if (RD_REQ) begin
        RX <= rx_c;
        RY <= ry_c;
      end
    end
  end

  reg_bank_dump_fsm #(
    .DEPTH (DEPTH)
  ) u_dump_fsm (
    .clk   (CLK),
    .rst_n (RST_N),
    .start (DUMP_START),
    .idx   (DUMP_IDX),
    .valid (DUMP_VALID),
    .busy  (BUSY)
  );

  // Dump port reads live contents so a write to the presented index shows through.
  always_comb begin
    DUMP_DATA = '0;
    if (DUMP_VALID) begin
      if (WE && (DIR_W == DUMP_IDX)) begin
        DUMP_DATA = Dato_Registro;
      end else begin
        DUMP_DATA = mem[DUMP_IDX];
      end
    end
  end

endmodule
